ddr_arw_bram_responder: RTL and testbench

Responder (slave) end of the combined-ARW DDR port driven by the DMA-to-DDR wrapper: single shared address channel with a write flag, plus W, B and R channels. It is backed by on-chip block RAM. It is used as a DDR stand-in for simulation and for DDR-less builds, so DMA channel traffic can run unchanged. It serves one transaction at a time in arrival order.

---
 rtl/ddr_arw_bram_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ddr_arw_bram_responder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arw_bram_responder.sv
// Block-RAM backed responder for the combined-ARW DDR port.
// One burst is served at a time. Reads are prefetched from the RAM into a
// two-entry skid buffer behind a registered R stage, so the R channel can
// stream one beat per cycle and still hold its outputs under back-pressure.
module ddr_arw_bram_responder #(
  parameter int DW  = 256,
  parameter int AW  = 10,
  parameter int IDW = 8
) (
  input  logic            dma_clk,
  input  logic            dma_reset,
  input  logic            arw_valid,
  output logic            arw_ready,
  input  logic [31:0]     arw_addr,
  input  logic [IDW-1:0]  arw_id,
  input  logic [7:0]      arw_len,
  input  logic [2:0]      arw_size,
  input  logic [1:0]      arw_burst,
  input  logic            arw_write,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [DW-1:0]   w_data,
  input  logic [DW/8-1:0] w_strb,
  input  logic            w_last,
  output logic            b_valid,
  input  logic            b_ready,
  output logic [IDW-1:0]  b_id,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [DW-1:0]   r_data,
  output logic [IDW-1:0]  r_id,
  output logic [1:0]      r_resp,
  output logic            r_last
);
  localparam int NB = DW / 8;
  localparam int L  = $clog2(NB);
  localparam logic [2:0]    SIZE_FULL = 3'(L);
  localparam logic [AW-1:0] ONE_IDX   = AW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t         state_r;
  logic           arw_ready_r;
  logic           w_ready_r;
  logic           b_valid_r;
  logic [IDW-1:0] b_id_r;
  logic           r_valid_r;
  logic [DW-1:0]  r_data_r;
  logic [IDW-1:0] r_id_r;
  logic [1:0]     r_resp_r;
  logic           r_last_r;

  // Latched burst attributes. ptr_r is the current write word, or the next
  // word to fetch during a read.
  logic [AW-1:0]  ptr_r;
  logic [IDW-1:0] id_r;
  logic [7:0]     len_r;
  logic           fixed_r;
  logic           size_ok_r;
  logic [8:0]     beat_cnt_r;
  logic [8:0]     issued_r;
  logic [8:0]     loaded_r;

  logic [DW-1:0]  mem_r [0:(1<<AW)-1];
  logic [DW-1:0]  rd_data_r;
  logic           rd_vld_r;
  logic [DW-1:0]  fifo_data_r [0:1];
  logic [1:0]     fifo_cnt_r;
  logic           fifo_rd_r;
  logic           fifo_wr_r;

  logic           arw_hs_s;
  logic           w_hs_s;
  logic           w_end_s;
  logic           mem_we_s;
  logic           mem_re_s;
  logic           r_pop_s;
  logic           out_free_s;
  logic           load_fifo_s;
  logic           load_ram_s;
  logic           load_s;
  logic           push_s;
  logic           issue_s;
  logic [AW-1:0]  arw_idx_s;
  logic [AW-1:0]  rd_idx_s;
  logic [DW-1:0]  load_data_s;
  logic [1:0]     fifo_cnt_next_s;
  logic           unused_addr_s;

  // Upper address bits alias and low bits are ignored for aligned access.
  assign unused_addr_s = ^{arw_addr[31:AW+L], arw_addr[L-1:0]};

  // Handshakes, read-pipeline steering and RAM port selection.
  always_comb begin
    arw_idx_s   = arw_addr[AW+L-1:L];
    arw_hs_s    = arw_valid && arw_ready_r;
    w_hs_s      = w_valid && w_ready_r;
    w_end_s     = w_hs_s && (w_last || (beat_cnt_r == {1'b0, len_r}));
    mem_we_s    = w_hs_s && size_ok_r;
    r_pop_s     = r_valid_r && r_ready;
    out_free_s  = !r_valid_r || r_ready;
    load_fifo_s = out_free_s && (fifo_cnt_r != 2'd0);
    load_ram_s  = out_free_s && (fifo_cnt_r == 2'd0) && rd_vld_r;
    load_s      = load_fifo_s || load_ram_s;
    push_s      = rd_vld_r && !load_ram_s;
    // A fetch is launched only if its data is guaranteed a skid slot.
    issue_s     = (state_r == RD_DATA) && (issued_r <= {1'b0, len_r}) &&
                  ((fifo_cnt_r + {1'b0, rd_vld_r}) <= 2'd1);
    mem_re_s    = (arw_hs_s && !arw_write) || issue_s;
    if (state_r == IDLE) begin
      rd_idx_s = arw_idx_s;
    end else begin
      rd_idx_s = ptr_r;
    end
    if (load_fifo_s) begin
      load_data_s = fifo_data_r[fifo_rd_r];
    end else begin
      load_data_s = rd_data_r;
    end
    fifo_cnt_next_s = fifo_cnt_r + {1'b0, push_s} - {1'b0, load_fifo_s};
  end

  // RAM array, registered read port and skid storage; none of it is reset.
  always_ff @(posedge dma_clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we_s && w_strb[i]) begin
        mem_r[ptr_r][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
    if (mem_re_s) begin
      rd_data_r <= mem_r[rd_idx_s];
    end
    if (push_s) begin
      fifo_data_r[fifo_wr_r] <= rd_data_r;
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge dma_clk or posedge dma_reset) begin
    if (dma_reset) begin
      state_r     <= IDLE;
      arw_ready_r <= 1'b0;
      w_ready_r   <= 1'b0;
      b_valid_r   <= 1'b0;
      b_id_r      <= '0;
      r_valid_r   <= 1'b0;
      r_data_r    <= '0;
      r_id_r      <= '0;
      r_resp_r    <= 2'b00;
      r_last_r    <= 1'b0;
      ptr_r       <= '0;
      id_r        <= '0;
      len_r       <= 8'd0;
      fixed_r     <= 1'b0;
      size_ok_r   <= 1'b0;
      beat_cnt_r  <= 9'd0;
      issued_r    <= 9'd0;
      loaded_r    <= 9'd0;
      rd_vld_r    <= 1'b0;
      fifo_cnt_r  <= 2'd0;
      fifo_rd_r   <= 1'b0;
      fifo_wr_r   <= 1'b0;
    end else begin
      rd_vld_r <= mem_re_s;
      case (state_r)
        IDLE: begin
          arw_ready_r <= 1'b1;
          if (arw_hs_s) begin
            arw_ready_r <= 1'b0;
            id_r        <= arw_id;
            len_r       <= arw_len;
            fixed_r     <= (arw_burst == 2'b00);
            size_ok_r   <= (arw_size == SIZE_FULL);
            beat_cnt_r  <= 9'd0;
            loaded_r    <= 9'd0;
            if (arw_write) begin
              state_r   <= WR_DATA;
              w_ready_r <= 1'b1;
              ptr_r     <= arw_idx_s;
            end else begin
              // The first word is fetched in this cycle straight off arw_addr.
              state_r  <= RD_DATA;
              issued_r <= 9'd1;
              ptr_r    <= (arw_burst == 2'b00) ? arw_idx_s : (arw_idx_s + ONE_IDX);
            end
          end
        end
        WR_DATA: begin
          if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + 9'd1;
            if (!fixed_r) begin
              ptr_r <= ptr_r + ONE_IDX;
            end
            // The final RAM write lands on this same edge, before B is seen.
            if (w_end_s) begin
              state_r   <= WR_RESP;
              w_ready_r <= 1'b0;
              b_valid_r <= 1'b1;
              b_id_r    <= id_r;
            end
          end
        end
        WR_RESP: begin
          if (b_ready) begin
            b_valid_r   <= 1'b0;
            state_r     <= IDLE;
            arw_ready_r <= 1'b1;
          end
        end
        RD_DATA: begin
          if (issue_s) begin
            issued_r <= issued_r + 9'd1;
            if (!fixed_r) begin
              ptr_r <= ptr_r + ONE_IDX;
            end
          end
          if (push_s) begin
            fifo_wr_r <= ~fifo_wr_r;
          end
          if (load_fifo_s) begin
            fifo_rd_r <= ~fifo_rd_r;
          end
          fifo_cnt_r <= fifo_cnt_next_s;
          if (load_s) begin
            r_valid_r <= 1'b1;
            r_data_r  <= size_ok_r ? load_data_s : '0;
            r_resp_r  <= size_ok_r ? 2'b00 : 2'b10;
            r_id_r    <= id_r;
            r_last_r  <= (loaded_r == {1'b0, len_r});
            loaded_r  <= loaded_r + 9'd1;
          end else if (r_pop_s) begin
            r_valid_r <= 1'b0;
            r_last_r  <= 1'b0;
            if (r_last_r) begin
              state_r     <= IDLE;
              arw_ready_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign arw_ready = arw_ready_r;
  assign w_ready   = w_ready_r;
  assign b_valid   = b_valid_r;
  assign b_id      = b_id_r;
  assign r_valid   = r_valid_r;
  assign r_data    = r_data_r;
  assign r_id      = r_id_r;
  assign r_resp    = r_resp_r;
  assign r_last    = r_last_r;

endmodule

// File: tb/tb_ddr_arw_bram_responder.sv
// Scoreboard bench: drivers push expected B/R responses computed from a
// word-array memory model; a monitor pops and compares on each handshake.
module tb_ddr_arw_bram_responder;
  localparam int DW    = 256;
  localparam int AW    = 10;
  localparam int IDW   = 8;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic           dma_clk = 1'b0;
  logic           dma_reset = 1'b1;
  logic           arw_valid = 1'b0;
  logic           arw_ready;
  logic [31:0]    arw_addr = 32'd0;
  logic [IDW-1:0] arw_id = 8'd0;
  logic [7:0]     arw_len = 8'd0;
  logic [2:0]     arw_size = 3'd0;
  logic [1:0]     arw_burst = 2'd0;
  logic           arw_write = 1'b0;
  logic           w_valid = 1'b0;
  logic           w_ready;
  logic [DW-1:0]  w_data = '0;
  logic [NB-1:0]  w_strb = '0;
  logic           w_last = 1'b0;
  logic           b_valid;
  logic           b_ready = 1'b1;
  logic [IDW-1:0] b_id;
  logic           r_valid;
  logic           r_ready = 1'b1;
  logic [DW-1:0]  r_data;
  logic [IDW-1:0] r_id;
  logic [1:0]     r_resp;
  logic           r_last;

  ddr_arw_bram_responder #(.DW(DW), .AW(AW), .IDW(IDW)) dut (
    .dma_clk(dma_clk), .dma_reset(dma_reset),
    .arw_valid(arw_valid), .arw_ready(arw_ready), .arw_addr(arw_addr),
    .arw_id(arw_id), .arw_len(arw_len), .arw_size(arw_size),
    .arw_burst(arw_burst), .arw_write(arw_write),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_id(r_id), .r_resp(r_resp), .r_last(r_last)
  );

  always #5 dma_clk = ~dma_clk;

  typedef struct {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic           last;
    int             beat;
    bit             tput;
  } rexp_t;

  rexp_t          rq[$];
  logic [IDW-1:0] bq[$];
  logic [DW-1:0]  model_mem [DEPTH];
  logic [DW-1:0]  wdat [256];
  logic [NB-1:0]  wstrb [256];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int arw_hs_cyc = 0;
  int rbeats = 0;
  int rmode = 0;
  int bmode = 0;
  logic w_ready_at_arw = 1'b0;

  always @(posedge dma_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // r_ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
  initial begin
    int k = 0;
    forever begin
      @(posedge dma_clk); #1;
      case (rmode)
        1:       r_ready = ((k % 4) == 0) || ((k % 4) == 3);
        2:       r_ready = 1'($urandom_range(0, 1));
        default: r_ready = 1'b1;
      endcase
      k++;
    end
  end

  initial begin
    forever begin
      @(posedge dma_clk); #1;
      b_ready = (bmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every B/R handshake and R stability under stall.
  initial begin
    rexp_t e;
    logic stall_prev = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic [IDW-1:0] p_id = '0;
    logic p_last = 1'b0;
    int first_cyc = 0;
    forever begin
      @(negedge dma_clk);
      if (dma_reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("r_hold_valid", r_valid, 1'b1);
          chk("r_hold_data", r_data, p_data);
          chk("r_hold_id", r_id, p_id);
          chk("r_hold_last", r_last, p_last);
        end
        stall_prev = r_valid && !r_ready;
        p_data = r_data;
        p_id = r_id;
        p_last = r_last;
        if (r_valid && r_ready) begin
          if (rq.size() == 0) begin
            fail("r_unexpected", 1, 0);
          end else begin
            e = rq.pop_front();
            chk("r_data", r_data, e.data);
            chk("r_id", r_id, e.id);
            chk("r_resp", r_resp, e.resp);
            chk("r_last", r_last, e.last);
            if (e.tput) begin
              if (e.beat == 0) begin
                first_cyc = cyc;
                if (cyc - arw_hs_cyc > 2) fail("r_first_latency", cyc - arw_hs_cyc, 2);
                else total++;
              end
              if (e.last) chk("r_burst_cycles", 32'(cyc - first_cyc), 32'(e.beat));
            end
          end
          rbeats++;
        end
        if (b_valid && b_ready) begin
          if (bq.size() == 0) fail("b_unexpected", 1, 0);
          else chk("b_id", b_id, bq.pop_front());
        end
      end
    end
  end

  task automatic wait_rdy(input bit is_w, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 5000) begin
      @(negedge dma_clk);
      if (is_w ? w_ready : arw_ready) begin
        ok = 1'b1;
        if (!is_w) begin
          arw_hs_cyc = cyc;
          w_ready_at_arw = w_ready;
        end
        @(posedge dma_clk); #1;
        break;
      end
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 5000) begin
      @(posedge dma_clk);
      n++;
    end
    if (n >= 5000) begin
      fail("drain_timeout", rq.size() + bq.size(), 0);
      rq.delete();
      bq.delete();
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input bit gaps, input bit early_w);
    int idx;
    bit ok;
    idx = int'((addr >> 5) % DEPTH);
    for (int b = 0; b < nbeats; b++) begin
      if (size == 3'd5)
        for (int k = 0; k < NB; k++)
          if (wstrb[b][k]) model_mem[idx][8*k +: 8] = wdat[b][8*k +: 8];
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    bq.push_back(id);
    @(posedge dma_clk); #1;
    arw_valid = 1'b1; arw_addr = addr; arw_id = id; arw_len = len;
    arw_size = size; arw_burst = burst; arw_write = 1'b1;
    if (early_w) begin
      w_valid = 1'b1; w_data = wdat[0]; w_strb = wstrb[0]; w_last = (nbeats == 1);
    end
    wait_rdy(1'b0, ok);
    arw_valid = 1'b0;
    if (!ok) begin
      fail("arw_timeout", 0, 1);
      w_valid = 1'b0;
      return;
    end
    if (early_w) chk("w_ready_during_arw", w_ready_at_arw, 1'b0);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          w_valid = 1'b0;
          @(posedge dma_clk); #1;
        end
      end
      w_valid = 1'b1; w_data = wdat[b]; w_strb = wstrb[b]; w_last = (b == nbeats - 1);
      wait_rdy(1'b1, ok);
      if (!ok) begin
        fail("w_timeout", b, nbeats);
        break;
      end
    end
    w_valid = 1'b0;
    w_last = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit tput,
                         input bit wait_done);
    int idx;
    bit ok;
    rexp_t e;
    idx = int'((addr >> 5) % DEPTH);
    for (int b = 0; b <= int'(len); b++) begin
      e.data = (size == 3'd5) ? model_mem[idx] : '0;
      e.id = id;
      e.resp = (size == 3'd5) ? 2'b00 : 2'b10;
      e.last = (b == int'(len));
      e.beat = b;
      e.tput = tput;
      rq.push_back(e);
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    @(posedge dma_clk); #1;
    arw_valid = 1'b1; arw_addr = addr; arw_id = id; arw_len = len;
    arw_size = size; arw_burst = burst; arw_write = 1'b0;
    wait_rdy(1'b0, ok);
    arw_valid = 1'b0;
    if (!ok) begin
      fail("arw_timeout", 0, 1);
      rq.delete();
      return;
    end
    if (wait_done) wait_idle();
  endtask

  task automatic fill_beats(input int n, input bit full_strb);
    for (int b = 0; b < n; b++) begin
      wdat[b] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      wstrb[b] = full_strb ? {NB{1'b1}} : NB'($urandom);
    end
  endtask

  initial begin
    int base;
    int n;
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    int nb;

    // Reset state.
    repeat (3) @(posedge dma_clk);
    #1;
    chk("rst_arw_ready", arw_ready, 1'b0);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_b_id", b_id, '0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_last", r_last, 1'b0);
    chk("rst_r_data", r_data, '0);
    chk("rst_r_id", r_id, '0);
    chk("rst_r_resp", r_resp, 2'b00);
    @(posedge dma_clk); #2;
    dma_reset = 1'b0;
    #1 chk("arw_ready_at_release", arw_ready, 1'b0);
    @(posedge dma_clk); #1;
    chk("arw_ready_after_release", arw_ready, 1'b1);

    // Preload the whole memory so every later read has a defined model value.
    for (int q = 0; q < 4; q++) begin
      fill_beats(256, 1'b1);
      do_write(32'(q * 256 * NB), 8'(q), 8'd255, 3'd5, 2'b01, 256, 1'b0, 1'b0);
    end

    // Basic write then read-back, with W offered alongside ARW.
    wdat[0] = {32{8'h11}}; wdat[1] = {32{8'h22}}; wdat[2] = {32{8'h33}}; wdat[3] = {32{8'h44}};
    for (int b = 0; b < 4; b++) wstrb[b] = {NB{1'b1}};
    do_write(32'h0000_0100, 8'hE0, 8'd3, 3'd5, 2'b01, 4, 1'b0, 1'b1);
    do_read(32'h0000_0100, 8'hE0, 8'd3, 3'd5, 2'b01, 1'b1, 1'b1);

    // Byte strobes on word 8.
    wdat[0] = {32{8'hFF}}; wstrb[0] = {NB{1'b1}};
    do_write(32'(8 * NB), 8'h21, 8'd0, 3'd5, 2'b01, 1, 1'b0, 1'b0);
    wdat[0] = {32{8'hAA}}; wstrb[0] = NB'(32'h0000_000F);
    do_write(32'(8 * NB), 8'h22, 8'd0, 3'd5, 2'b01, 1, 1'b0, 1'b0);
    do_read(32'(8 * NB), 8'h23, 8'd0, 3'd5, 2'b01, 1'b0, 1'b1);

    // Back-pressure, then full-rate streaming.
    rmode = 1;
    do_read(32'h0000_2000, 8'h31, 8'd15, 3'd5, 2'b01, 1'b0, 1'b1);
    rmode = 0;
    do_read(32'h0000_2000, 8'h32, 8'd15, 3'd5, 2'b01, 1'b1, 1'b1);

    // Wrap at top of memory, and FIXED bursts.
    do_read(32'((DEPTH - 2) * NB), 8'h41, 8'd3, 3'd5, 2'b01, 1'b1, 1'b1);
    fill_beats(4, 1'b1);
    do_write(32'(100 * NB), 8'h42, 8'd3, 3'd5, 2'b00, 4, 1'b0, 1'b0);
    do_read(32'(100 * NB), 8'h43, 8'd3, 3'd5, 2'b01, 1'b0, 1'b1);
    do_read(32'(100 * NB), 8'h44, 8'd3, 3'd5, 2'b00, 1'b0, 1'b1);

    // Error sizes and early w_last.
    fill_beats(4, 1'b1);
    do_write(32'(200 * NB), 8'h51, 8'd3, 3'd2, 2'b01, 4, 1'b0, 1'b0);
    do_read(32'(200 * NB), 8'h52, 8'd3, 3'd5, 2'b01, 1'b0, 1'b1);
    do_read(32'(200 * NB), 8'h53, 8'd1, 3'd2, 2'b01, 1'b0, 1'b1);
    fill_beats(8, 1'b1);
    do_write(32'(300 * NB), 8'h54, 8'd7, 3'd5, 2'b01, 2, 1'b0, 1'b0);
    do_read(32'(300 * NB), 8'h55, 8'd7, 3'd5, 2'b01, 1'b0, 1'b1);

    // Reset in the middle of an 8-beat read.
    base = rbeats;
    do_read(32'(512 * NB), 8'h5A, 8'd7, 3'd5, 2'b01, 1'b0, 1'b0);
    n = 0;
    while (rbeats < base + 3 && n < 1000) begin
      @(posedge dma_clk);
      n++;
    end
    if (n >= 1000) fail("rst_wait_beats", rbeats - base, 3);
    #2 dma_reset = 1'b1;
    #1;
    chk("midrst_r_valid", r_valid, 1'b0);
    chk("midrst_arw_ready", arw_ready, 1'b0);
    rq.delete();
    repeat (3) @(posedge dma_clk);
    #2 dma_reset = 1'b0;
    #1 chk("midrst_arw_ready_release", arw_ready, 1'b0);
    @(posedge dma_clk); #1;
    chk("midrst_arw_ready_next", arw_ready, 1'b1);
    do_read(32'(512 * NB), 8'h5B, 8'd7, 3'd5, 2'b01, 1'b1, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      rmode = $urandom_range(0, 2);
      bmode = $urandom_range(0, 1);
      addr  = $urandom;
      len   = 8'($urandom_range(0, 7));
      size  = ($urandom_range(0, 5) == 0) ? 3'd2 : 3'd5;
      burst = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        fill_beats(int'(len) + 1, 1'b0);
        nb = int'(len) + 1;
        if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, int'(len) + 1);
        do_write(addr, 8'($urandom), len, size, burst, nb, 1'b1, 1'b0);
      end else begin
        do_read(addr, 8'($urandom), len, size, burst, rmode == 0, 1'b1);
      end
    end

    rmode = 0;
    bmode = 0;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
